// File: rtl/bht_counter_ctrl.sv
// Branch history table controller: initialises a 64x2 SRAM of saturating counters,
// serves one-cycle lookups with update bypass, and trains counters on resolved branches.
module bht_counter_ctrl #(
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pred_req_valid,
  input  logic [5:0] pred_req_idx,
  output logic       pred_req_ready,
  output logic       pred_resp_valid,
  input  logic       pred_resp_ready,
  output logic       pred_resp_taken,
  output logic [1:0] pred_resp_ctr,
  input  logic       upd_valid,
  input  logic [5:0] upd_idx,
  input  logic       upd_taken,
  input  logic [1:0] upd_ctr,
  output logic       init_done,
  output logic       sram_write_en,
  output logic [5:0] sram_write_addr,
  output logic [1:0] sram_write_data,
  output logic       sram_read_en,
  output logic [5:0] sram_read_addr,
  input  logic [1:0] sram_read_data
);

  localparam logic [5:0] LAST_ADDR = 6'(ENTRIES - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [5:0] init_addr_r;
  logic [5:0] init_addr_s;

  logic       resp_valid_r;
  logic       fresh_r;
  logic       byp_hit_r;
  logic [1:0] byp_ctr_r;
  logic [1:0] held_ctr_r;

  logic       run_s;
  logic       accept_s;
  logic       upd_hit_s;
  logic [1:0] upd_new_s;
  logic [1:0] resp_ctr_s;

  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

  assign run_s     = (state_r == ST_RUN);
  assign upd_new_s = sat_next(upd_ctr, upd_taken);
  assign upd_hit_s = run_s && upd_valid && (upd_idx == pred_req_idx);

  // State register and init address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      init_addr_r <= 6'd0;
    end else begin
      state_r     <= state_s;
      init_addr_r <= init_addr_s;
    end
  end

  // Next-state: sweep every address once, then run forever
  always_comb begin
    state_s     = state_r;
    init_addr_s = init_addr_r;
    case (state_r)
      ST_INIT: begin
        init_addr_s = init_addr_r + 6'd1;
        if (init_addr_r == LAST_ADDR) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_s     = ST_RUN;
        init_addr_s = 6'd0;
      end
      default: begin
        state_s     = ST_INIT;
        init_addr_s = 6'd0;
      end
    endcase
  end

  // Write port: init sweep owns it, otherwise training updates write with zero latency.
  // rst_n gates the init write so nothing is written while the table is held in reset.
  always_comb begin
    sram_write_en   = 1'b0;
    sram_write_addr = upd_idx;
    sram_write_data = upd_new_s;
    if (!run_s) begin
      sram_write_en   = rst_n;
      sram_write_addr = init_addr_r;
      sram_write_data = INIT_CTR;
    end else if (upd_valid) begin
      sram_write_en   = 1'b1;
      sram_write_addr = upd_idx;
      sram_write_data = upd_new_s;
    end else begin
      sram_write_en   = 1'b0;
    end
  end

  assign init_done      = run_s;
  assign pred_req_ready = run_s && !(resp_valid_r && !pred_resp_ready);
  assign accept_s       = pred_req_valid && pred_req_ready;
  assign sram_read_en   = accept_s;
  assign sram_read_addr = pred_req_idx;

  // Response tracking: fresh_r marks the first cycle of a response, when SRAM data is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      fresh_r      <= 1'b0;
      byp_hit_r    <= 1'b0;
      byp_ctr_r    <= 2'b00;
      held_ctr_r   <= 2'b00;
    end else begin
      fresh_r   <= accept_s;
      byp_hit_r <= accept_s && upd_hit_s;
      byp_ctr_r <= upd_new_s;
      if (accept_s) begin
        resp_valid_r <= 1'b1;
      end else if (pred_resp_ready) begin
        resp_valid_r <= 1'b0;
      end else begin
        resp_valid_r <= resp_valid_r;
      end
      if (fresh_r) begin
        held_ctr_r <= resp_ctr_s;
      end else begin
        held_ctr_r <= held_ctr_r;
      end
    end
  end

  // Response data: bypassed update wins over the SRAM read; later cycles replay the hold register
  always_comb begin
    resp_ctr_s = held_ctr_r;
    if (fresh_r) begin
      resp_ctr_s = byp_hit_r ? byp_ctr_r : sram_read_data;
    end else begin
      resp_ctr_s = held_ctr_r;
    end
  end

  assign pred_resp_valid = resp_valid_r;
  assign pred_resp_ctr   = resp_ctr_s;
  assign pred_resp_taken = resp_ctr_s[1];

endmodule

// File: tb/tb_bht_counter_ctrl.sv
// Directed bench for bht_counter_ctrl with a read-first SRAM model and a response scoreboard.
module tb_bht_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_req_valid;
  logic [5:0] pred_req_idx;
  logic       pred_req_ready;
  logic       pred_resp_valid;
  logic       pred_resp_ready;
  logic       pred_resp_taken;
  logic [1:0] pred_resp_ctr;
  logic       upd_valid;
  logic [5:0] upd_idx;
  logic       upd_taken;
  logic [1:0] upd_ctr;
  logic       init_done;
  logic       sram_write_en;
  logic [5:0] sram_write_addr;
  logic [1:0] sram_write_data;
  logic       sram_read_en;
  logic [5:0] sram_read_addr;
  logic [1:0] sram_read_data;

  logic [1:0] mem [64];
  logic [1:0] model [64];
  logic [1:0] sb_q [$];
  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;

  bht_counter_ctrl #(.ENTRIES(64), .INIT_CTR(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req_valid(pred_req_valid), .pred_req_idx(pred_req_idx), .pred_req_ready(pred_req_ready),
    .pred_resp_valid(pred_resp_valid), .pred_resp_ready(pred_resp_ready),
    .pred_resp_taken(pred_resp_taken), .pred_resp_ctr(pred_resp_ctr),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ctr(upd_ctr),
    .init_done(init_done),
    .sram_write_en(sram_write_en), .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data),
    .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr), .sram_read_data(sram_read_data)
  );

  always #5 clk = ~clk;

  // Read-first SRAM: a same-cycle write is not visible to the read
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    if (sram_read_en) sram_read_data <= mem[sram_read_addr];
  end

  function automatic logic [1:0] model_sat(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on response handshake, push on lookup accept, then track training writes
  task automatic sb();
    logic [1:0] e;
    if (pred_resp_valid && pred_resp_ready) begin
      resp_cnt++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_resp", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_resp_ctr", int'(pred_resp_ctr), int'(e));
        chk("sb_resp_taken", int'(pred_resp_taken), int'(e[1]));
      end
    end
    if (pred_req_valid && pred_req_ready) begin
      e = model[pred_req_idx];
      if (upd_valid && init_done && upd_idx == pred_req_idx) e = model_sat(upd_ctr, upd_taken);
      sb_q.push_back(e);
    end
    if (upd_valid && init_done) model[upd_idx] = model_sat(upd_ctr, upd_taken);
  endtask

  task automatic neg();
    @(negedge clk);
    sb();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 2'b01;
    sb_q.delete();
  endtask

  initial begin
    logic [1:0] uc [4];
    logic       ut [4];
    logic [1:0] ue [4];
    int         base_cnt;
    uc = '{2'd1, 2'd2, 2'd3, 2'd0};
    ut = '{1'b1, 1'b1, 1'b1, 1'b0};
    ue = '{2'd2, 2'd3, 2'd3, 2'd0};

    rst_n = 1'b0; pred_req_valid = 1'b0; pred_req_idx = 6'd0; pred_resp_ready = 1'b1;
    upd_valid = 1'b0; upd_idx = 6'd0; upd_taken = 1'b0; upd_ctr = 2'd0;
    model_reset();

    // Reset state
    neg();
    chk("rst_write_en", int'(sram_write_en), 0);
    chk("rst_read_en", int'(sram_read_en), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_req_ready", int'(pred_req_ready), 0);
    chk("rst_resp_valid", int'(pred_resp_valid), 0);
    chk("rst_resp_ctr", int'(pred_resp_ctr), 0);
    chk("rst_resp_taken", int'(pred_resp_taken), 0);
    pos();
    rst_n = 1'b1;

    // Initialisation sweep, with updates offered and ignored
    upd_valid = 1'b1; upd_idx = 6'd40; upd_ctr = 2'd3; upd_taken = 1'b0;
    for (int i = 0; i < 64; i++) begin
      neg();
      chk("init_we", int'(sram_write_en), 1);
      chk("init_addr", int'(sram_write_addr), i);
      chk("init_data", int'(sram_write_data), 1);
      chk("init_done_low", int'(init_done), 0);
      chk("init_ready_low", int'(pred_req_ready), 0);
      pos();
    end
    upd_valid = 1'b0;

    // First lookup after init
    pred_req_valid = 1'b1; pred_req_idx = 6'd5;
    neg();
    chk("run_init_done", int'(init_done), 1);
    chk("run_we_idle", int'(sram_write_en), 0);
    chk("lk5_read_en", int'(sram_read_en), 1);
    chk("lk5_read_addr", int'(sram_read_addr), 5);
    pos();
    pred_req_valid = 1'b0;
    neg();
    chk("lk5_resp_valid", int'(pred_resp_valid), 1);
    chk("lk5_read_en_idle", int'(sram_read_en), 0);
    pos();
    neg();
    chk("lk5_resp_drop", int'(pred_resp_valid), 0);
    pos();

    // Saturating training sequence on idx 9
    for (int k = 0; k < 4; k++) begin
      upd_valid = 1'b1; upd_idx = 6'd9; upd_ctr = uc[k]; upd_taken = ut[k];
      neg();
      chk("upd9_we", int'(sram_write_en), 1);
      chk("upd9_addr", int'(sram_write_addr), 9);
      chk("upd9_data", int'(sram_write_data), int'(ue[k]));
      pos();
    end
    upd_valid = 1'b0;

    // Same-cycle lookup and update bypass on idx 12
    pred_req_valid = 1'b1; pred_req_idx = 6'd12;
    upd_valid = 1'b1; upd_idx = 6'd12; upd_ctr = 2'd1; upd_taken = 1'b1;
    neg();
    chk("byp_read_en", int'(sram_read_en), 1);
    chk("byp_write_data", int'(sram_write_data), 2);
    pos();
    pred_req_valid = 1'b0; upd_valid = 1'b0;
    neg();
    chk("byp_resp_valid", int'(pred_resp_valid), 1);
    chk("byp_resp_ctr", int'(pred_resp_ctr), 2);
    chk("byp_resp_taken", int'(pred_resp_taken), 1);
    pos();

    // Stalled response on idx 3 while idx 3 is retrained
    pred_resp_ready = 1'b0;
    pred_req_valid = 1'b1; pred_req_idx = 6'd3;
    neg();
    pos();
    pred_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      upd_valid = 1'b1; upd_idx = 6'd3; upd_ctr = 2'(k); upd_taken = k[0];
      neg();
      chk("stall_valid", int'(pred_resp_valid), 1);
      chk("stall_ctr", int'(pred_resp_ctr), 1);
      chk("stall_taken", int'(pred_resp_taken), 0);
      chk("stall_ready", int'(pred_req_ready), 0);
      pos();
    end
    upd_valid = 1'b0; pred_resp_ready = 1'b1;
    neg();
    chk("stall_release_ready", int'(pred_req_ready), 1);
    chk("stall_release_ctr", int'(pred_resp_ctr), 1);
    pos();
    neg();
    chk("stall_drop", int'(pred_resp_valid), 0);
    pos();

    // Back-to-back lookups on idx 0..7
    base_cnt = resp_cnt;
    for (int k = 0; k < 9; k++) begin
      pred_req_valid = (k < 8); pred_req_idx = 6'(k);
      neg();
      if (k >= 1) chk("b2b_valid", int'(pred_resp_valid), 1);
      if (k < 8) chk("b2b_ready", int'(pred_req_ready), 1);
      pos();
    end
    pred_req_valid = 1'b0;
    neg();
    chk("b2b_drop", int'(pred_resp_valid), 0);
    chk("b2b_count", resp_cnt - base_cnt, 8);
    pos();

    // Reset during RUN discards an outstanding response
    pred_resp_ready = 1'b0;
    pred_req_valid = 1'b1; pred_req_idx = 6'd7;
    neg();
    pos();
    pred_req_valid = 1'b0;
    neg();
    chk("midrun_pending", int'(pred_resp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", int'(pred_resp_valid), 0);
    chk("midrun_rst_ctr", int'(pred_resp_ctr), 0);
    chk("midrun_rst_done", int'(init_done), 0);
    chk("midrun_rst_ready", int'(pred_req_ready), 0);
    chk("midrun_rst_we", int'(sram_write_en), 0);
    model_reset();
    pos();
    rst_n = 1'b1; pred_resp_ready = 1'b1;

    // Reset again at init address 30
    for (int i = 0; i < 30; i++) begin
      neg();
      pos();
    end
    neg();
    chk("abort_at_addr", int'(sram_write_addr), 30);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we", int'(sram_write_en), 0);
    chk("abort_done", int'(init_done), 0);
    pos();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      neg();
      chk("reinit_addr", int'(sram_write_addr), i);
      chk("reinit_done_low", int'(init_done), 0);
      pos();
    end
    neg();
    chk("reinit_done", int'(init_done), 1);
    pos();

    // Lookup after re-init sees the fresh initial value
    pred_req_valid = 1'b1; pred_req_idx = 6'd30;
    neg();
    pos();
    pred_req_valid = 1'b0;
    neg();
    chk("reinit_lk_valid", int'(pred_resp_valid), 1);
    pos();
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bht_counter_ctrl.md
BHT_COUNTER_CTRL -- requirements
Module: bht_counter_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, meaning the table depth, fixed to 64 (6-bit index).
REQ-002 SHALL have parameter INIT_CTR, default 2'b01, meaning the counter value written to every entry after reset (weakly not-taken).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pred_req_valid  input  1  prediction lookup request.
REQ-006 pred_req_idx  input  6  table index to look up.
REQ-007 pred_req_ready  output  1  lookup accepted when valid && ready.
REQ-008 pred_resp_valid  output  1  prediction result available.
REQ-009 pred_resp_ready  input  1  consumer accepts result.
REQ-010 pred_resp_taken  output  1  predicted direction; equals pred_resp_ctr[1].
REQ-011 pred_resp_ctr  output  2  counter value returned for the lookup.
REQ-012 upd_valid  input  1  training update; always accepted while init_done=1.
REQ-013 upd_idx  input  6  index to train.
REQ-014 upd_taken  input  1  resolved branch outcome.
REQ-015 upd_ctr  input  2  counter value the predictor returned for this branch.
REQ-016 init_done  output  1  high once table initialisation has completed.
REQ-017 sram_write_en, sram_write_addr[5:0], sram_write_data[1:0]  outputs  drive the 64x2 1R1W SRAM write port.
REQ-018 sram_read_en, sram_read_addr[5:0]  outputs; sram_read_data[1:0]  input  SRAM read port; data valid exactly 1 cycle after the read is issued.

Function
REQ-019 SHALL implement a two-state FSM: INIT and RUN.
REQ-020 In INIT, SHALL write INIT_CTR to addresses 0,1,...,63 in consecutive cycles (sram_write_en=1), then enter RUN on the cycle after writing address 63; INIT therefore lasts exactly 64 cycles.
REQ-021 In INIT, SHALL hold pred_req_ready=0 and init_done=0; upd_valid SHALL be ignored.
REQ-022 In RUN, init_done=1.
REQ-023 Update path SHALL write in the same cycle as upd_valid (0-cycle latency, combinational address/data).
REQ-024 New counter = min(upd_ctr+1, 3) if upd_taken, else max(upd_ctr-1, 0); saturation at 3 and 0 is mandatory (no 2-bit wrap).
REQ-025 pred_req_ready = RUN && !(pred_resp_valid && !pred_resp_ready).
REQ-026 On lookup accept in cycle N, SHALL issue sram_read_en with sram_read_addr=pred_req_idx in cycle N; pred_resp_valid SHALL rise in N+1.
REQ-027 Same-cycle bypass: if an update to the same index writes in cycle N, the response SHALL carry the newly written counter, not the SRAM output.
REQ-028 Response data SHALL be captured into a hold register in N+1; while pred_resp_valid && !pred_resp_ready, outputs SHALL stay stable, unaffected by later SRAM output changes or later updates.
REQ-029 Back-to-back lookups SHALL sustain one per cycle while pred_resp_ready=1; at most one response is outstanding.
REQ-030 pred_resp_valid SHALL drop the cycle after handshake unless a new lookup was accepted in the handshake cycle.
REQ-031 sram_read_en SHALL be 0 in any cycle with no accepted lookup.

Reset
REQ-032 While rst_n=0: FSM=INIT, init address counter=0, pred_resp_valid=0, init_done=0, pred_req_ready=0, sram_write_en=0, sram_read_en=0, pred_resp_ctr=0, pred_resp_taken=0.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL abort immediately (asynchronously); any outstanding response is discarded, and initialisation restarts from address 0 after release.

Verification
REQ-034 Release reset -> 64 consecutive writes of 2'b01 to addresses 0..63, init_done rises on cycle 64, lookup of idx 5 returns ctr=1, taken=0.
REQ-035 Updates idx 9 with (ctr=1,taken=1), (2,1), (3,1), (0,0) -> written values 2, 3, 3, 0.
REQ-036 Lookup idx 12 and update idx 12 (ctr=1,taken=1) in the same cycle -> response ctr=2, taken=1.
REQ-037 Lookup idx 3, pred_resp_ready=0 for 4 cycles while updating idx 3 -> response held at original value, pred_req_ready=0 throughout, released on ready.
REQ-038 Lookups on idx 0..7 in consecutive cycles with pred_resp_ready=1 -> 8 responses in 8 consecutive cycles, in order.
REQ-039 Assert rst_n=0 at init address 30 -> after release, writes restart at address 0 and init_done rises 64 cycles later.
